fifo_write_arbiter: RTL and testbench
=====================================

Name: fifo_write_arbiter

Overview:
- Packet-aware round-robin arbiter that shares the write side of one router input FIFO (dclk FIFO write port, DSIZE-wide items) among NREQ requesters.
- Grants one flit per cycle and locks the winner until its tail flit is written.
- Honours the FIFO full flag.
- Sits in the router between the upstream port muxes and the FIFO write interface, clocked by the FIFO's write clock.

Parameters:
- NREQ, 4, number of requesters (2..8).
- NREQ_LOG2, 2, width of the owner index; must equal ceil(log2(NREQ)).
- DSIZE, 4, flit width; must match the downstream FIFO DSIZE.

Ports:
- clk  input  1  single clock; the FIFO write-domain clock.
- reset  input  1  synchronous, active-low: reset==0 at posedge clk resets the block.
- req  input  NREQ  per-requester flit valid.
- tail  input  NREQ  per-requester marker: the presented flit is the last flit of its packet.
- data_in  input  NREQ*DSIZE  packed flits; requester i occupies bits [i*DSIZE +: DSIZE].
- fifo_full  input  1  full flag from the FIFO.
- gnt  output  NREQ  one-hot; gnt[i]=1 means requester i's flit is consumed this cycle.
- fifo_write  output  1  write strobe to the FIFO.
- fifo_item  output  DSIZE  flit to the FIFO.
- locked  output  1  a multi-flit packet is in progress.
- owner  output  NREQ_LOG2  index of the current or last winner.

Behaviour:
- State: st ∈ {IDLE, LOCKED}, rr_ptr (last serviced index), owner register.
- Reset values: st=IDLE, rr_ptr=NREQ-1 (requester 0 has first priority), owner=0, locked=0.
- While reset is active, gnt=0 and fifo_write=0 combinationally.
- gnt, fifo_write and fifo_item are combinational from the state and inputs, so acceptance has zero latency.
- Invariants:
  - fifo_write == |gnt.
  - fifo_item = data_in slice of the granted requester; when fifo_write=0, fifo_item=0.
- fifo_full=1 forces gnt=0 and fifo_write=0 in every state. State, rr_ptr and owner hold.
- IDLE:
  - Winner = first i with req[i]=1, scanning rr_ptr+1, rr_ptr+2, ... modulo NREQ (wraps NREQ-1 → 0).
  - No req: no grant, state holds.
  - Winner w with tail[w]=1: grant w, stay IDLE, rr_ptr<=w, owner<=w.
  - Winner w with tail[w]=0: grant w, st<=LOCKED, owner<=w.
- LOCKED:
  - Only owner can be granted. All other requests are ignored, regardless of priority.
  - req[owner]=0: no grant, stay LOCKED. Bubbles are legal and there is no timeout.
  - req[owner]=1 and !fifo_full: grant.
  - Granted flit with tail=1: st<=IDLE, rr_ptr<=owner.
  - Granted flit with tail=0: stay LOCKED.
- locked = (st==LOCKED).
- Fairness: after a packet from w completes, w has the lowest priority. Each requester waits at most NREQ-1 packets.
- Reset mid-packet (reset==0 while LOCKED) returns to IDLE with rr_ptr=NREQ-1. The partial packet already in the FIFO is not retracted.
- req and tail are don't-care when the block is not granting. tail is sampled only on the granted requester.

Decomposition:
- Shared package/header holds:
  - state encodings: ARB_IDLE=0, ARB_LOCKED=1.
  - DCLK_FIFO_DSIZE default, so arbiter and FIFO agree on flit width.
- Natural sub-module: rr_pick
  - Combinational round-robin priority picker.
  - Inputs: req vector and rr_ptr.
  - Outputs: one-hot and index of the winner, plus a valid flag.
  - Reused by the router output allocator.

Test Plan:
1. After reset, req=4'b1111, tail=4'b1111, fifo_full=0, held for 5 cycles:
   - gnt sequence 0001, 0010, 0100, 1000, 0001.
   - fifo_item matches each requester's data (e.g. data_in=16'h4321 gives items 1,2,3,4,1).
2. Requester 1 sends a 3-flit packet (tail on 3rd flit) while req[2] is held high throughout:
   - gnt=0010 for 3 cycles and locked=1 during flits 1-2.
   - gnt=0100 on the cycle after the tail.
3. Lock with bubble: owner=0 drops req for 2 cycles mid-packet while req[3]=1:
   - gnt=0000, fifo_write=0, locked stays 1.
   - Owner resumes and finishes; then gnt=1000.
4. fifo_full=1 for 3 cycles with all req high:
   - gnt=0, fifo_write=0, rr_ptr and owner unchanged.
   - When full deasserts, the grant goes to the same requester that would have won before.
5. reset=0 for 1 cycle while locked by requester 2:
   - locked=0 and owner=0 next cycle.
   - With req=4'b0101, the next grant is 0001.
6. Wrap-around: rr_ptr=NREQ-1 (last winner 3), req=4'b1001, tail=4'b1111:
   - Grant 0001, then 1000, then 0001.

Source files
------------

// File: rtl/fifo_write_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// fifo_write_arbiter_pkg : shared encodings and widths for the FIFO write arbiter
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fifo_write_arbiter_pkg;

  // Shared with the dclk FIFO so the arbiter and the FIFO agree on flit width
  localparam int DCLK_FIFO_DSIZE = 4;

  localparam logic [0:0] ARB_IDLE   = 1'b0;
  localparam logic [0:0] ARB_LOCKED = 1'b1;

endpackage

`default_nettype wire

// File: rtl/fifo_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// fifo_write_arbiter_if : requester-side and FIFO-side signals of the arbiter
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface fifo_write_arbiter_if
  import fifo_write_arbiter_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int NREQ_LOG2 = 2,
  parameter int DSIZE     = DCLK_FIFO_DSIZE
);
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       tail;
  logic [NREQ*DSIZE-1:0] data_in;
  logic                  fifo_full;
  logic [NREQ-1:0]       gnt;
  logic                  fifo_write;
  logic [DSIZE-1:0]      fifo_item;
  logic                  locked;
  logic [NREQ_LOG2-1:0]  owner;

  modport master (
    output req, tail, data_in, fifo_full,
    input  gnt, fifo_write, fifo_item, locked, owner
  );

  modport slave (
    input  req, tail, data_in, fifo_full,
    output gnt, fifo_write, fifo_item, locked, owner
  );
endinterface

`default_nettype wire

// File: rtl/fifo_write_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// fifo_write_arbiter_rr_pick : combinational round-robin picker, scan starts after ptr_i
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fifo_write_arbiter_rr_pick #(
  parameter int NREQ      = 4,
  parameter int NREQ_LOG2 = 2
) (
  input  wire logic [NREQ-1:0]      req_i,
  input  wire logic [NREQ_LOG2-1:0] ptr_i,
  output logic      [NREQ-1:0]      onehot_o,
  output logic      [NREQ_LOG2-1:0] idx_o,
  output logic                      valid_o
);

  int cand;

  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    cand     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(ptr_i) + k) % NREQ;
      if (!valid_o && req_i[cand]) begin
        valid_o        = 1'b1;
        idx_o          = NREQ_LOG2'(cand);
        onehot_o[cand] = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fifo_write_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_write_arbiter : packet-locking round-robin arbiter for one FIFO write port
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fifo_write_arbiter
  import fifo_write_arbiter_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int NREQ_LOG2 = 2,
  parameter int DSIZE     = DCLK_FIFO_DSIZE
) (
  input wire logic            clk,
  input wire logic            reset,
  fifo_write_arbiter_if.slave bus
);

  logic [0:0]           st_q, st_d;
  logic [NREQ_LOG2-1:0] rr_ptr_q, rr_ptr_d;
  logic [NREQ_LOG2-1:0] owner_q, owner_d;

  logic [NREQ-1:0]      pick_onehot;
  logic [NREQ_LOG2-1:0] pick_idx;
  logic                 pick_valid;
  logic [NREQ-1:0]      gnt;
  logic [NREQ_LOG2-1:0] gnt_idx;

  fifo_write_arbiter_rr_pick #(
    .NREQ      (NREQ),
    .NREQ_LOG2 (NREQ_LOG2)
  ) u_rr_pick (
    .req_i    (bus.req),
    .ptr_i    (rr_ptr_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .valid_o  (pick_valid)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      st_q     <= ARB_IDLE;
      rr_ptr_q <= NREQ_LOG2'(NREQ - 1);
      owner_q  <= '0;
    end else begin
      st_q     <= st_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
    end
  end

  // Grant is combinational so a flit is accepted in the cycle it is presented
  always_comb begin
    gnt     = '0;
    gnt_idx = (st_q == ARB_LOCKED) ? owner_q : pick_idx;
    if (reset && !bus.fifo_full) begin
      if (st_q == ARB_LOCKED) begin
        gnt[owner_q] = bus.req[owner_q];
      end else if (pick_valid) begin
        gnt = pick_onehot;
      end
    end
  end

  always_comb begin
    st_d     = st_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    if (|gnt) begin
      owner_d = gnt_idx;
      if (bus.tail[gnt_idx]) begin
        st_d     = ARB_IDLE;
        rr_ptr_d = gnt_idx;
      end else begin
        st_d     = ARB_LOCKED;
      end
    end
  end

  always_comb begin
    bus.gnt        = gnt;
    bus.fifo_write = |gnt;
    bus.fifo_item  = (|gnt) ? bus.data_in[int'(gnt_idx)*DSIZE +: DSIZE] : '0;
    bus.locked     = (st_q == ARB_LOCKED);
    bus.owner      = owner_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_write_arbiter : directed self-checking bench for fifo_write_arbiter
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fifo_write_arbiter;

  localparam int NREQ      = 4;
  localparam int NREQ_LOG2 = 2;
  localparam int DSIZE     = 4;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_pass;

  fifo_write_arbiter_if #(.NREQ(NREQ), .NREQ_LOG2(NREQ_LOG2), .DSIZE(DSIZE)) bus ();

  fifo_write_arbiter #(
    .NREQ      (NREQ),
    .NREQ_LOG2 (NREQ_LOG2),
    .DSIZE     (DSIZE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [DSIZE-1:0] exp_item(input logic [NREQ-1:0] g,
                                                input logic [NREQ*DSIZE-1:0] d);
    logic [DSIZE-1:0] r;
    r = '0;
    for (int i = 0; i < NREQ; i++)
      if (g[i]) r = d[i*DSIZE +: DSIZE];
    return r;
  endfunction

  // Present one cycle of inputs, check the combinational outputs, then clock
  task automatic step(input string tag, input logic [3:0] r, input logic [3:0] t,
                      input logic f, input logic [3:0] eg);
    bus.req       = r;
    bus.tail      = t;
    bus.fifo_full = f;
    #2;
    chk({tag, ".gnt"},  32'(bus.gnt), 32'(eg));
    chk({tag, ".wr"},   32'(bus.fifo_write), 32'(|eg));
    chk({tag, ".item"}, 32'(bus.fifo_item), 32'(exp_item(eg, bus.data_in)));
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    reset = 1'b0;
    bus.req = 4'b1111;
    bus.tail = 4'b1111;
    bus.fifo_full = 1'b0;
    bus.data_in = 16'h4321;

    // Reset held: no grants even with all requests up
    @(posedge clk); #1;
    step("rst", 4'b1111, 4'b1111, 1'b0, 4'b0000);
    chk("rst.locked", 32'(bus.locked), 32'd0);
    chk("rst.owner",  32'(bus.owner),  32'd0);
    reset = 1'b1;

    // 1: single-flit packets rotate from requester 0
    step("t1a", 4'b1111, 4'b1111, 1'b0, 4'b0001);
    step("t1b", 4'b1111, 4'b1111, 1'b0, 4'b0010);
    step("t1c", 4'b1111, 4'b1111, 1'b0, 4'b0100);
    step("t1d", 4'b1111, 4'b1111, 1'b0, 4'b1000);
    step("t1e", 4'b1111, 4'b1111, 1'b0, 4'b0001);
    chk("t1.owner", 32'(bus.owner), 32'd0);

    // 2: requester 1 three-flit packet, requester 2 waiting
    bus.data_in = 16'h9A5C;
    step("t2f1", 4'b0110, 4'b0000, 1'b0, 4'b0010);
    chk("t2.lock1", 32'(bus.locked), 32'd1);
    chk("t2.own1",  32'(bus.owner),  32'd1);
    step("t2f2", 4'b0110, 4'b0000, 1'b0, 4'b0010);
    chk("t2.lock2", 32'(bus.locked), 32'd1);
    step("t2f3", 4'b0110, 4'b0010, 1'b0, 4'b0010);
    chk("t2.unlock", 32'(bus.locked), 32'd0);
    step("t2nx", 4'b0100, 4'b0100, 1'b0, 4'b0100);

    // 3: owner 0 bubbles for two cycles while requester 3 waits
    step("t3f1", 4'b0001, 4'b0000, 1'b0, 4'b0001);
    step("t3b1", 4'b1000, 4'b1000, 1'b0, 4'b0000);
    chk("t3.lockb1", 32'(bus.locked), 32'd1);
    step("t3b2", 4'b1000, 4'b1000, 1'b0, 4'b0000);
    chk("t3.lockb2", 32'(bus.locked), 32'd1);
    step("t3f2", 4'b1001, 4'b0001, 1'b0, 4'b0001);
    chk("t3.unlock", 32'(bus.locked), 32'd0);
    step("t3nx", 4'b1000, 4'b1000, 1'b0, 4'b1000);

    // 4: FIFO full stalls everything; the pending winner is preserved
    for (int i = 0; i < 3; i++) begin
      step("t4full", 4'b1111, 4'b1111, 1'b1, 4'b0000);
      chk("t4.owner", 32'(bus.owner), 32'd3);
    end
    step("t4go", 4'b1111, 4'b1111, 1'b0, 4'b0001);

    // 5: reset mid-packet owned by requester 2
    step("t5f1", 4'b0100, 4'b0000, 1'b0, 4'b0100);
    chk("t5.lock",  32'(bus.locked), 32'd1);
    chk("t5.own",   32'(bus.owner),  32'd2);
    reset = 1'b0;
    step("t5rst", 4'b0100, 4'b0000, 1'b0, 4'b0000);
    reset = 1'b1;
    chk("t5.lock0", 32'(bus.locked), 32'd0);
    chk("t5.own0",  32'(bus.owner),  32'd0);
    step("t5nx", 4'b0101, 4'b0101, 1'b0, 4'b0001);

    // 6: wrap-around from last winner 3
    step("t6set", 4'b1000, 4'b1000, 1'b0, 4'b1000);
    step("t6a",   4'b1001, 4'b1111, 1'b0, 4'b0001);
    step("t6b",   4'b1001, 4'b1111, 1'b0, 4'b1000);
    step("t6c",   4'b1001, 4'b1111, 1'b0, 4'b0001);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
